conv_engine: RTL and testbench

- Parametrised successor to the single-channel convolution block: multi-channel 2-D valid convolution with configurable stride, fixed-point output scaling, optional ReLU and saturation.
- Sequential single-MAC datapath with an internal FSM; no separate linebuffer/PE handshake.
- Sits between the feature-map memory (flattened input vectors) and the next layer.
- Streams each result as it completes and also presents the full flattened output map.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_mac_unit.sv | 45 ++++
 rtl/conv_engine.sv | 176 +++++++++++++++++
 tb/tb_conv_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-channel convolution engine.
// Also hosts the element ordering used by the conv_block family.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int out_dim(input int size, input int k, input int s);
        return (size - k) / s + 1;
    endfunction

    function automatic longint sat_signed(input longint value, input int p);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (p - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    // Channel-major, then row-major flattening.
    function automatic int elem_idx(input int c, input int row, input int col,
                                    input int h, input int w);
        return (c * h + row) * w + col;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with shift, optional ReLU and saturating
// output stage.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int P     = 8,
    parameter int ACC_W = 19,
    parameter int FRAC  = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic                relu_en,
    input  logic signed [P-1:0] pix,
    input  logic signed [P-1:0] wgt,
    output logic signed [P-1:0] result
);

    logic signed [ACC_W-1:0] acc;
    logic signed [2*P-1:0]   prod;
    logic signed [ACC_W-1:0] shifted;
    longint                  r;

    assign prod = pix * wgt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    always_comb begin
        shifted = acc >>> FRAC;
        r = longint'(shifted);
        if (relu_en && r < 0) r = 0;
        r = sat_signed(r, P);
        result = r[P-1:0];
    end

endmodule

// File: rtl/conv_engine.sv
// Multi-channel strided valid convolution with a single sequential MAC;
// streams each result and assembles the flattened output map.
module conv_engine
    import conv_pkg::*;
#(
    parameter int kernel_size = 2,
    parameter int data_width  = 4,
    parameter int data_height = 4,
    parameter int point_width = 8,
    parameter int channels    = 1,
    parameter int stride      = 1,
    parameter int frac_shift  = 0,
    localparam int OW    = out_dim(data_width, kernel_size, stride),
    localparam int OH    = out_dim(data_height, kernel_size, stride),
    localparam int N     = OW * OH,
    localparam int KKC   = kernel_size * kernel_size * channels,
    localparam int ACC_W = 2 * point_width + clog2(KKC) + 1,
    localparam int IW    = (N > 1) ? clog2(N) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    relu_en,
    input  logic [channels*data_height*data_width*point_width-1:0] data,
    input  logic [channels*kernel_size*kernel_size*point_width-1:0] weights,
    output logic                    busy,
    output logic                    result_valid,
    output logic [point_width-1:0]  result_data,
    output logic [IW-1:0]           result_index,
    output logic [N*point_width-1:0] data_out,
    output logic                    convolution_done
);

    localparam int K  = kernel_size;
    localparam int W  = data_width;
    localparam int H  = data_height;
    localparam int P  = point_width;
    localparam int C  = channels;
    localparam int S  = stride;
    localparam int KB = clog2(K) + 1;
    localparam int CB = clog2(C) + 1;
    localparam int XB = clog2(OW) + 1;
    localparam int YB = clog2(OH) + 1;

    if (K > W || K > H || S < 1) begin : g_bad_cfg
        $error("conv_engine: kernel larger than map or stride < 1");
    end

    state_t             state_q, state_d;
    logic [C*H*W*P-1:0] data_r;
    logic [C*K*K*P-1:0] wgt_r;
    logic               relu_r;
    logic [KB-1:0]      kx, ky;
    logic [CB-1:0]      ch;
    logic [XB-1:0]      ox;
    logic [YB-1:0]      oy;
    logic               accept, last_tap, last_win;
    int                 d_idx, w_idx, o_idx;
    logic signed [P-1:0] pix, wgt, mac_res;

    assign accept   = (state_q == IDLE) && start;
    assign last_tap = (kx == KB'(K - 1)) && (ky == KB'(K - 1)) && (ch == CB'(C - 1));
    assign last_win = (ox == XB'(OW - 1)) && (oy == YB'(OH - 1));

    always_comb begin
        d_idx = elem_idx(int'(ch), int'(oy) * S + int'(ky),
                         int'(ox) * S + int'(kx), H, W);
        w_idx = elem_idx(int'(ch), int'(ky), int'(kx), K, K);
        o_idx = int'(oy) * OW + int'(ox);
    end

    assign pix = data_r[d_idx*P +: P];
    assign wgt = wgt_r[w_idx*P +: P];

    conv_mac_unit #(
        .P     (P),
        .ACC_W (ACC_W),
        .FRAC  (frac_shift)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept || state_q == WRITE),
        .enable  (state_q == MAC),
        .relu_en (relu_r),
        .pix     (pix),
        .wgt     (wgt),
        .result  (mac_res)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        busy             = 1'b0;
        result_valid     = 1'b0;
        convolution_done = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = MAC;
            MAC: begin
                busy = 1'b1;
                if (last_tap) state_d = WRITE;
            end
            WRITE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_d      = last_win ? DONE : MAC;
            end
            DONE: begin
                convolution_done = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result_data  = result_valid ? mac_res : '0;
    assign result_index = result_valid ? IW'(o_idx) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_r   <= '0;
            wgt_r    <= '0;
            relu_r   <= 1'b0;
            data_out <= '0;
            kx       <= '0;
            ky       <= '0;
            ch       <= '0;
            ox       <= '0;
            oy       <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    data_r   <= data;
                    wgt_r    <= weights;
                    relu_r   <= relu_en;
                    data_out <= '0;
                    kx       <= '0;
                    ky       <= '0;
                    ch       <= '0;
                    ox       <= '0;
                    oy       <= '0;
                end
                MAC: begin
                    if (kx == KB'(K - 1)) begin
                        kx <= '0;
                        if (ky == KB'(K - 1)) begin
                            ky <= '0;
                            ch <= (ch == CB'(C - 1)) ? '0 : ch + CB'(1);
                        end else begin
                            ky <= ky + KB'(1);
                        end
                    end else begin
                        kx <= kx + KB'(1);
                    end
                end
                WRITE: begin
                    data_out[o_idx*P +: P] <= mac_res;
                    if (ox == XB'(OW - 1)) begin
                        ox <= '0;
                        oy <= oy + YB'(1);
                    end else begin
                        ox <= ox + XB'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: default map, saturation, ReLU,
// multi-channel stride, fractional shift, ignored restart and async reset.
module tb_conv_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic         st0, relu0, busy0, rv0, done0;
    logic [127:0] d0;
    logic [31:0]  w0;
    logic [7:0]   rd0;
    logic [3:0]   ri0;
    logic [71:0]  do0;

    logic         st1, relu1, busy1, rv1, done1;
    logic [255:0] d1;
    logic [63:0]  w1;
    logic [7:0]   rd1;
    logic [1:0]   ri1;
    logic [31:0]  do1;

    logic         st2, relu2, busy2, rv2, done2;
    logic [127:0] d2;
    logic [31:0]  w2;
    logic [7:0]   rd2;
    logic [3:0]   ri2;
    logic [71:0]  do2;

    conv_engine u0 (
        .clock(clock), .reset(reset), .start(st0), .relu_en(relu0),
        .data(d0), .weights(w0), .busy(busy0), .result_valid(rv0),
        .result_data(rd0), .result_index(ri0), .data_out(do0),
        .convolution_done(done0)
    );

    conv_engine #(.channels(2), .stride(2)) u1 (
        .clock(clock), .reset(reset), .start(st1), .relu_en(relu1),
        .data(d1), .weights(w1), .busy(busy1), .result_valid(rv1),
        .result_data(rd1), .result_index(ri1), .data_out(do1),
        .convolution_done(done1)
    );

    conv_engine #(.frac_shift(2)) u2 (
        .clock(clock), .reset(reset), .start(st2), .relu_en(relu2),
        .data(d2), .weights(w2), .busy(busy2), .result_valid(rv2),
        .result_data(rd2), .result_index(ri2), .data_out(do2),
        .convolution_done(done2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int e_pos[9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    int e_neg[9] = '{-14, -18, -22, -30, -34, -38, -46, -50, -54};
    int e_zero[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e_lo[9] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    int e_hi[9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    int e_shp[9] = '{3, 4, 5, 7, 8, 9, 11, 12, 13};
    int e_shn[9] = '{-4, -5, -6, -8, -9, -10, -12, -13, -14};

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ramp16();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i + 1);
        return v;
    endfunction

    function automatic logic [31:0] fill4(input logic [7:0] b);
        return {b, b, b, b};
    endfunction

    // Runs one 4x4/2x2 convolution on u0 (sel=0) or u2 (sel=1) and checks
    // every streamed result, its timing, done timing and the output map.
    task automatic run_u(input int sel, input logic relu, input int exp[9],
                         input string tag);
        int           cnt;
        int           done_k;
        logic         rv, bz, dn;
        logic [7:0]   rd;
        logic [3:0]   ri;
        logic [71:0]  dout;
        logic [127:0] dsave;
        cnt = 0;
        done_k = 0;
        @(negedge clock);
        if (sel != 0) begin relu2 = relu; st2 = 1'b1; end
        else begin relu0 = relu; st0 = 1'b1; end
        @(posedge clock);
        #1;
        st0 = 1'b0;
        st2 = 1'b0;
        dsave = (sel != 0) ? d2 : d0;
        if (sel != 0) begin relu2 = ~relu; d2 = ~d2; end
        else begin relu0 = ~relu; d0 = ~d0; end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            rv = (sel != 0) ? rv2 : rv0;
            bz = (sel != 0) ? busy2 : busy0;
            dn = (sel != 0) ? done2 : done0;
            rd = (sel != 0) ? rd2 : rd0;
            ri = (sel != 0) ? ri2 : ri0;
            if (k == 1) check({tag, "_busy1"}, bz, 1);
            if (rv) begin
                if (cnt < 9) begin
                    check({tag, "_idx"}, ri, cnt);
                    check({tag, "_val"}, $signed(rd), exp[cnt]);
                    check({tag, "_cyc"}, k, (cnt + 1) * 5);
                end
                cnt++;
            end
            if (dn) begin
                done_k = k;
                check({tag, "_busy_at_done"}, bz, 0);
            end
        end
        check({tag, "_count"}, cnt, 9);
        check({tag, "_done_cyc"}, done_k, 46);
        dout = (sel != 0) ? do2 : do0;
        for (int i = 0; i < 9; i++)
            check({tag, "_map"}, $signed(dout[i*8 +: 8]), exp[i]);
        if (sel != 0) d2 = dsave;
        else d0 = dsave;
    endtask

    initial begin
        int cnt;
        int done_k;
        reset = 1'b0;
        st0 = 0; st1 = 0; st2 = 0;
        relu0 = 0; relu1 = 0; relu2 = 0;
        d0 = '0; d1 = '0; d2 = '0;
        w0 = '0; w1 = '0; w2 = '0;
        #12;
        check("rst_busy", busy0, 0);
        check("rst_valid", rv0, 0);
        check("rst_done", done0, 0);
        check("rst_map", do0, 0);
        reset = 1'b1;

        d0 = ramp16();
        w0 = fill4(8'h01);
        run_u(0, 1'b0, e_pos, "base");

        d0 = {16{8'h7F}};
        w0 = fill4(8'h80);
        run_u(0, 1'b0, e_lo, "sat_lo");
        w0 = fill4(8'h7F);
        run_u(0, 1'b0, e_hi, "sat_hi");

        d0 = ramp16();
        w0 = fill4(8'hFF);
        run_u(0, 1'b0, e_neg, "neg");
        run_u(0, 1'b1, e_zero, "relu");

        d2 = ramp16();
        w2 = fill4(8'h01);
        run_u(1, 1'b0, e_shp, "shp");
        w2 = fill4(8'hFF);
        run_u(1, 1'b0, e_shn, "shn");

        d1 = {{16{8'h02}}, {16{8'h01}}};
        w1 = {8{8'h01}};
        cnt = 0;
        done_k = 0;
        @(negedge clock);
        st1 = 1'b1;
        @(posedge clock);
        #1 st1 = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (rv1) begin
                if (cnt < 4) begin
                    check("mc_idx", ri1, cnt);
                    check("mc_val", $signed(rd1), 12);
                    check("mc_cyc", k, (cnt + 1) * 9);
                end
                cnt++;
            end
            if (done1) done_k = k;
        end
        check("mc_count", cnt, 4);
        check("mc_done_cyc", done_k, 37);
        check("mc_map", do1, {4{8'd12}});

        d0 = ramp16();
        w0 = fill4(8'h01);
        cnt = 0;
        @(negedge clock);
        relu0 = 1'b0;
        st0 = 1'b1;
        @(posedge clock);
        #1 st0 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (rv0) begin
                if (cnt < 4) begin
                    check("rs_val", $signed(rd0), e_pos[cnt]);
                    check("rs_cyc", k, (cnt + 1) * 5);
                end
                cnt++;
            end
            if (k == 10) st0 = 1'b1;
            if (k == 11) st0 = 1'b0;
        end
        check("rs_count", cnt, 4);
        #2 reset = 1'b0;
        #1;
        check("ar_busy", busy0, 0);
        check("ar_valid", rv0, 0);
        check("ar_data", rd0, 0);
        check("ar_index", ri0, 0);
        check("ar_done", done0, 0);
        check("ar_map", do0, 0);
        @(negedge clock);
        reset = 1'b1;
        run_u(0, 1'b0, e_pos, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
